// File: rtl/bat_amateur_pkg.sv
// Shared Bat Amateur bus definitions: bus direction and count direction encodings.
// No ports. Imported by bidi_counter_reg, count_step and their bench.
package bat_amateur_pkg;

  // RW encoding seen by a bus register: read loads from the bus, write drives it.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // DIR encoding for counters.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/bidi_counter_reg_if.sv
// Control and status bundle of a bidi_counter_reg.
// master: bus controller (drives SYNC_CLEAR, ENABLE, RW, COUNT, DIR; sees VALUE, ZERO, CARRY).
// slave : the counter register itself.
// The DATA bus is a resolved tristate net and stays a top-level inout of the register.
interface bidi_counter_reg_if #(
  parameter int unsigned BUS_WIDTH = 16
);

  logic                 SYNC_CLEAR;
  logic                 ENABLE;
  logic                 RW;
  logic                 COUNT;
  logic                 DIR;
  logic [BUS_WIDTH-1:0] VALUE;
  logic                 ZERO;
  logic                 CARRY;

  modport master (
    output SYNC_CLEAR, ENABLE, RW, COUNT, DIR,
    input  VALUE, ZERO, CARRY
  );

  modport slave (
    input  SYNC_CLEAR, ENABLE, RW, COUNT, DIR,
    output VALUE, ZERO, CARRY
  );

endinterface

// File: rtl/count_step.sv
// Combinational +/-1 step with wrap or saturation and terminal-count detect.
// Ports: value_i (current value), dir_i (DIR_UP/DIR_DOWN), saturate_i (clamp at limits),
//        count_en_i (step requested), next_value_c (stepped value), carry_c (limit hit).
// Macro BIDI_COUNTER_DOWN_EN: when undefined dir_i is ignored and no down-limit logic exists.
module count_step
  import bat_amateur_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 16
) (
  input  logic [BUS_WIDTH-1:0] value_i,
  input  logic                 dir_i,
  input  logic                 saturate_i,
  input  logic                 count_en_i,
  output logic [BUS_WIDTH-1:0] next_value_c,
  output logic                 carry_c
);

  localparam logic [BUS_WIDTH-1:0] ALL_ONES = '1;

  logic at_max_c;

  assign at_max_c = (value_i == ALL_ONES);

`ifdef BIDI_COUNTER_DOWN_EN
  logic at_min_c;
  logic down_c;

  assign at_min_c = (value_i == '0);
  assign down_c   = (dir_i == DIR_DOWN);
`else
  logic unused_dir;

  assign unused_dir = dir_i;
`endif

  // Carry flags every step taken at a limit, whether it wraps or clamps.
  always_comb begin
    next_value_c = value_i;
    carry_c      = 1'b0;
    if (count_en_i) begin
`ifdef BIDI_COUNTER_DOWN_EN
      if (down_c) begin
        carry_c = at_min_c;
        if (!(at_min_c && saturate_i)) begin
          next_value_c = value_i - BUS_WIDTH'(1);
        end
      end else
`endif
      begin
        carry_c = at_max_c;
        if (!(at_max_c && saturate_i)) begin
          next_value_c = value_i + BUS_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bidi_counter_reg.sv
// Bidirectional counter register on the Bat Amateur data bus (PC, SP, loop counters).
// Ports: CLOCK (rising edge), RESET (async, active low), bus (bidi_counter_reg_if.slave:
//        SYNC_CLEAR, ENABLE, RW, COUNT, DIR in; VALUE, ZERO, CARRY out), DATA (registered
//        tristate drive, sampled on loads).
// Macro BIDI_COUNTER_DOWN_EN: enables DIR-selected down counting; otherwise always counts up.
module bidi_counter_reg
  import bat_amateur_pkg::*;
#(
  parameter int unsigned          BUS_WIDTH   = 16,
  parameter logic [BUS_WIDTH-1:0] RESET_VALUE = '0,
  parameter bit                   COUNT_EN    = 1'b1,
  parameter bit                   SATURATE    = 1'b0
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  bidi_counter_reg_if.slave    bus,
  inout  wire  [BUS_WIDTH-1:0] DATA
);

  logic [BUS_WIDTH-1:0] value_q, value_d;
  logic                 carry_q, carry_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 data_oe_q, data_oe_d;

  logic                 load_c;
  logic                 step_en_c;
  logic [BUS_WIDTH-1:0] step_value_c;
  logic                 step_carry_c;

  assign load_c    = bus.ENABLE && (bus.RW == RW_READ);
  assign step_en_c = COUNT_EN && bus.COUNT && !load_c;

  count_step #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_count_step (
    .value_i      (value_q),
    .dir_i        (bus.DIR),
    .saturate_i   (SATURATE),
    .count_en_i   (step_en_c),
    .next_value_c (step_value_c),
    .carry_c      (step_carry_c)
  );

  // Value priority: clear, load, step. Drive always carries the pre-update value,
  // which gives post-increment fetch when write and count coincide.
  always_comb begin
    value_d   = value_q;
    carry_d   = 1'b0;
    data_d    = value_q;
    data_oe_d = 1'b0;
    if (bus.SYNC_CLEAR) begin
      value_d = RESET_VALUE;
    end else if (load_c) begin
      value_d = DATA;
    end else begin
      value_d = step_value_c;
      carry_d = step_carry_c;
    end
    if (bus.ENABLE) begin
      case (bus.RW)
        RW_WRITE: data_oe_d = 1'b1;
        RW_READ:  data_oe_d = 1'b0;
        // Unknown direction with the bus enabled: drive X rather than guess.
        default: begin
          data_oe_d = 1'b1;
          data_d    = 'x;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      value_q   <= RESET_VALUE;
      carry_q   <= 1'b0;
      data_q    <= '0;
      data_oe_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      carry_q   <= carry_d;
      data_q    <= data_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign DATA      = data_oe_q ? data_q : {BUS_WIDTH{1'bz}};
  assign bus.VALUE = value_q;
  assign bus.ZERO  = (value_q == '0);
  assign bus.CARRY = carry_q;

endmodule

// File: tb/tb_bidi_counter_reg.sv
// Self-checking bench for bidi_counter_reg: a wrapping instance (RESET_VALUE 16'h0100)
// and a saturating instance (RESET_VALUE 16'h0001). Pullups on both buses make a
// released DATA read as all-ones.
module tb_bidi_counter_reg;
  import bat_amateur_pkg::*;

  localparam int unsigned BW       = 16;
  localparam logic [BW-1:0] RELEASED = 16'hFFFF;
  localparam logic [BW-1:0] RV_WRAP  = 16'h0100;

  typedef struct packed {
    logic [BW-1:0] value;
    logic          carry;
    logic          zero;
    logic [BW-1:0] data;
  } obs_t;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic [BW-1:0] drv_w, drv_s;
  logic          oe_w, oe_s;
  wire  [BW-1:0] data_w, data_s;

  assign data_w = oe_w ? drv_w : {BW{1'bz}};
  assign data_s = oe_s ? drv_s : {BW{1'bz}};

  for (genvar i = 0; i < BW; i++) begin : g_pull
    pullup (data_w[i]);
    pullup (data_s[i]);
  end

  bidi_counter_reg_if #(.BUS_WIDTH(BW)) iw ();
  bidi_counter_reg_if #(.BUS_WIDTH(BW)) is ();

  bidi_counter_reg #(
    .BUS_WIDTH(BW), .RESET_VALUE(RV_WRAP), .COUNT_EN(1'b1), .SATURATE(1'b0)
  ) dut_wrap (
    .CLOCK(CLOCK), .RESET(RESET), .bus(iw.slave), .DATA(data_w)
  );

  bidi_counter_reg #(
    .BUS_WIDTH(BW), .RESET_VALUE(16'h0001), .COUNT_EN(1'b1), .SATURATE(1'b1)
  ) dut_sat (
    .CLOCK(CLOCK), .RESET(RESET), .bus(is.slave), .DATA(data_s)
  );

  always #5 CLOCK = ~CLOCK;

  obs_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic obs_t mk(input logic [BW-1:0] v, input logic c, input logic [BW-1:0] d);
    mk = {v, c, (v == '0), d};
  endfunction

  function automatic obs_t obs_w();
    obs_w = {iw.VALUE, iw.CARRY, iw.ZERO, data_w};
  endfunction

  function automatic obs_t obs_s();
    obs_s = {is.VALUE, is.CARRY, is.ZERO, data_s};
  endfunction

  task automatic idle_w();
    iw.SYNC_CLEAR = 1'b0; iw.ENABLE = 1'b0; iw.RW = RW_READ;
    iw.COUNT = 1'b0; iw.DIR = DIR_UP; oe_w = 1'b0; drv_w = '0;
  endtask

  task automatic idle_s();
    is.SYNC_CLEAR = 1'b0; is.ENABLE = 1'b0; is.RW = RW_READ;
    is.COUNT = 1'b0; is.DIR = DIR_UP; oe_s = 1'b0; drv_s = '0;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic load_w(input logic [BW-1:0] v);
    idle_w();
    iw.ENABLE = 1'b1; oe_w = 1'b1; drv_w = v;
    tick();
    idle_w();
  endtask

  task automatic test_reset();
    obs_t o, e;
    idle_w(); idle_s();
    RESET = 1'b0;
    repeat (2) tick();
    sb_q.push_back(mk(RV_WRAP, 1'b0, RELEASED));
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_hold got=%h exp=%h", o, e); end
    RESET = 1'b1;
    iw.COUNT = 1'b1; iw.ENABLE = 1'b1; iw.RW = RW_WRITE;
    sb_q.push_back(mk(16'h0101, 1'b0, 16'h0100));
    sb_q.push_back(mk(16'h0102, 1'b0, 16'h0101));
    for (int i = 0; i < 2; i++) begin
      tick();
      o = obs_w(); e = sb_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_release_step%0d got=%h exp=%h", i, o, e); end
    end
    // Assert reset between edges, mid-count and mid-drive.
    #3 RESET = 1'b0;
    #1;
    sb_q.push_back(mk(RV_WRAP, 1'b0, RELEASED));
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_async got=%h exp=%h", o, e); end
    sb_q.push_back(mk(RV_WRAP, 1'b0, RELEASED));
    tick();
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_held_edge got=%h exp=%h", o, e); end
    RESET = 1'b1;
    iw.ENABLE = 1'b0;
    sb_q.push_back(mk(16'h0101, 1'b0, RELEASED));
    tick();
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_first_edge got=%h exp=%h", o, e); end
    idle_w();
  endtask

  task automatic test_load_beats_count();
    obs_t o, e;
    logic [BW-1:0] tbl [3];
    tbl[0] = 16'h1234; tbl[1] = 16'h0000; tbl[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      iw.ENABLE = 1'b1; iw.RW = RW_READ; iw.COUNT = 1'b1;
      oe_w = 1'b1; drv_w = tbl[i];
      sb_q.push_back(mk(tbl[i], 1'b0, tbl[i]));
      tick();
      o = obs_w(); e = sb_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL load_beats_count%0d got=%h exp=%h", i, o, e); end
    end
    idle_w();
    sb_q.push_back(mk(16'hFFFF, 1'b0, RELEASED));
    tick();
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL load_hold got=%h exp=%h", o, e); end
  endtask

  task automatic test_post_increment();
    obs_t o, e;
    load_w(16'h00FF);
    iw.ENABLE = 1'b1; iw.RW = RW_WRITE; iw.COUNT = 1'b1;
    sb_q.push_back(mk(16'h0100, 1'b0, 16'h00FF));
    tick();
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL post_inc_drive got=%h exp=%h", o, e); end
    idle_w();
    sb_q.push_back(mk(16'h0100, 1'b0, RELEASED));
    tick();
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL post_inc_release got=%h exp=%h", o, e); end
    // Plain writes back to back hold the bus and leave the value alone.
    iw.ENABLE = 1'b1; iw.RW = RW_WRITE;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(mk(16'h0100, 1'b0, 16'h0100));
      tick();
      o = obs_w(); e = sb_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL write_hold%0d got=%h exp=%h", i, o, e); end
    end
    idle_w();
  endtask

  task automatic test_wrap();
    obs_t o, e;
    load_w(16'hFFFF);
    iw.COUNT = 1'b1; iw.DIR = DIR_UP;
    sb_q.push_back(mk(16'h0000, 1'b1, RELEASED));
    iw.COUNT = 1'b1;
    tick();
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL wrap_up got=%h exp=%h", o, e); end
    iw.COUNT = 1'b0;
    sb_q.push_back(mk(16'h0000, 1'b0, RELEASED));
    tick();
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL wrap_carry_drop got=%h exp=%h", o, e); end
`ifdef BIDI_COUNTER_DOWN_EN
    iw.COUNT = 1'b1; iw.DIR = DIR_DOWN;
    sb_q.push_back(mk(16'hFFFF, 1'b1, RELEASED));
    sb_q.push_back(mk(16'hFFFE, 1'b0, RELEASED));
    for (int i = 0; i < 2; i++) begin
      tick();
      o = obs_w(); e = sb_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL wrap_down%0d got=%h exp=%h", i, o, e); end
    end
`endif
    idle_w();
  endtask

  task automatic test_sync_clear();
    obs_t o, e;
    load_w(16'h1234);
    iw.SYNC_CLEAR = 1'b1; iw.ENABLE = 1'b1; iw.RW = RW_WRITE; iw.COUNT = 1'b1;
    sb_q.push_back(mk(RV_WRAP, 1'b0, 16'h1234));
    tick();
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL clear_with_drive got=%h exp=%h", o, e); end
    load_w(16'hFFFF);
    iw.SYNC_CLEAR = 1'b1; iw.COUNT = 1'b1;
    sb_q.push_back(mk(RV_WRAP, 1'b0, RELEASED));
    tick();
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL clear_beats_wrap got=%h exp=%h", o, e); end
    idle_w();
    iw.SYNC_CLEAR = 1'b1; iw.ENABLE = 1'b1; iw.RW = RW_READ; oe_w = 1'b1; drv_w = 16'h5555;
    sb_q.push_back(mk(RV_WRAP, 1'b0, 16'h5555));
    tick();
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL clear_beats_load got=%h exp=%h", o, e); end
    idle_w();
  endtask

  task automatic test_direction();
    obs_t o, e;
    load_w(16'h0005);
    iw.COUNT = 1'b1; iw.DIR = DIR_DOWN;
`ifdef BIDI_COUNTER_DOWN_EN
    sb_q.push_back(mk(16'h0004, 1'b0, RELEASED));
`else
    sb_q.push_back(mk(16'h0006, 1'b0, RELEASED));
`endif
    tick();
    o = obs_w(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL direction got=%h exp=%h", o, e); end
    idle_w();
  endtask

  task automatic test_saturate();
    obs_t o, e;
    idle_s();
    is.ENABLE = 1'b1; oe_s = 1'b1; drv_s = 16'hFFFE;
    tick();
    idle_s();
    is.COUNT = 1'b1; is.DIR = DIR_UP;
    sb_q.push_back(mk(16'hFFFF, 1'b0, RELEASED));
    sb_q.push_back(mk(16'hFFFF, 1'b1, RELEASED));
    sb_q.push_back(mk(16'hFFFF, 1'b1, RELEASED));
    for (int i = 0; i < 3; i++) begin
      tick();
      o = obs_s(); e = sb_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL sat_up%0d got=%h exp=%h", i, o, e); end
    end
    is.COUNT = 1'b0;
    sb_q.push_back(mk(16'hFFFF, 1'b0, RELEASED));
    tick();
    o = obs_s(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL sat_up_idle got=%h exp=%h", o, e); end
`ifdef BIDI_COUNTER_DOWN_EN
    is.ENABLE = 1'b1; oe_s = 1'b1; drv_s = 16'h0001;
    tick();
    idle_s();
    is.COUNT = 1'b1; is.DIR = DIR_DOWN;
    sb_q.push_back(mk(16'h0000, 1'b0, RELEASED));
    sb_q.push_back(mk(16'h0000, 1'b1, RELEASED));
    sb_q.push_back(mk(16'h0000, 1'b1, RELEASED));
    for (int i = 0; i < 3; i++) begin
      tick();
      o = obs_s(); e = sb_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL sat_down%0d got=%h exp=%h", i, o, e); end
    end
    is.COUNT = 1'b0;
    sb_q.push_back(mk(16'h0000, 1'b0, RELEASED));
    tick();
    o = obs_s(); e = sb_q.pop_front(); checks++;
    if (o !== e) begin failures++; $display("FAIL sat_down_idle got=%h exp=%h", o, e); end
`endif
    idle_s();
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    logic [BW-1:0] mv, nv, r, ed;
    logic c, down;
    int op;
    load_w(16'hFFFD);
    mv = 16'hFFFD;
    for (int i = 0; i < 40; i++) begin
      idle_w();
      op = int'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       r = 16'h0000;
        1:       r = 16'hFFFF;
        default: r = 16'($urandom);
      endcase
`ifdef BIDI_COUNTER_DOWN_EN
      down = 1'($urandom_range(0, 1));
`else
      down = 1'b0;
`endif
      iw.DIR = down ? DIR_DOWN : DIR_UP;
      iw.SYNC_CLEAR = ($urandom_range(0, 7) == 0);
      iw.COUNT = (op >= 2) || ($urandom_range(0, 1) == 1 && op == 1);
      if (op == 1) begin iw.ENABLE = 1'b1; iw.RW = RW_READ; oe_w = 1'b1; drv_w = r; end
      if (op == 3) begin iw.ENABLE = 1'b1; iw.RW = RW_WRITE; end
      ed = (op == 1) ? r : (op == 3) ? mv : RELEASED;
      c  = 1'b0;
      if (iw.SYNC_CLEAR) nv = RV_WRAP;
      else if (op == 1) nv = r;
      else if (iw.COUNT && down) begin c = (mv == 16'h0000); nv = mv - 16'd1; end
      else if (iw.COUNT) begin c = (mv == 16'hFFFF); nv = mv + 16'd1; end
      else nv = mv;
      sb_q.push_back(mk(nv, c, ed));
      tick();
      o = obs_w(); e = sb_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL back_to_back%0d op=%0d got=%h exp=%h", i, op, o, e); end
      mv = nv;
    end
    idle_w();
  endtask

  initial begin
    idle_w();
    idle_s();
    RESET = 1'b0;
    test_reset();
    test_load_beats_count();
    test_post_increment();
    test_wrap();
    test_sync_clear();
    test_direction();
    test_saturate();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
